pulse_event_logger: RTL

//  Downstream consumer of the fast-to-slow pulse synchronizer; runs entirely in clk_slow.

---
 rtl/pulse_evt_pkg.sv | 12 +
 rtl/evt_sync_fifo.sv | 58 +++++
 rtl/pulse_event_logger.sv | 72 +++++++
 3 files changed

// File: rtl/pulse_evt_pkg.sv
// Shared types for the pulse event logger: record layout and the default timestamp width.
package pulse_evt_pkg;

    localparam int TS_W  = 16;
    localparam int REC_W = TS_W + 1;

    typedef struct packed {
        logic            gap_err;
        logic [TS_W-1:0] ts;
    } evt_rec_t;

endpackage

// File: rtl/evt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop frees room for a push in the same cycle.
module evt_sync_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk_slow,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  hold_q;
    logic          push_ok, pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Once drained, the head keeps showing the last record that left.
    assign dout = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk_slow) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            hold_q <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pulse_event_logger.sv
// Timestamps rising edges of a synchronized pulse, flags closely spaced events and
// queues the records for a valid/ready consumer.
module pulse_event_logger #(
    parameter int TS_W    = pulse_evt_pkg::TS_W,
    parameter int DEPTH   = 8,
    parameter int MIN_GAP = 3,
    parameter int DROP_W  = 8
) (
    input  logic                     clk_slow,
    input  logic                     rst,
    input  logic                     pulse_in,
    input  logic                     ts_clear,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic                     evt_gap_err,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int GW = $clog2(MIN_GAP + 1);

    logic            prev_in, have_prev, evt, gap_err, full, empty, pop, drop;
    logic [TS_W-1:0] ts_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [TS_W:0]   rec_in, rec_out;

    assign evt = pulse_in && !prev_in;
    assign pop = evt_valid && evt_ready;
    // gap_cnt counts edges strictly between two events, so the event spacing is gap_cnt+1.
    assign gap_err = have_prev && ((int'(gap_cnt) + 1) < MIN_GAP);
    assign drop    = evt && full && !pop;
    assign rec_in  = {gap_err, ts_cnt};

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            prev_in   <= 1'b0;
            ts_cnt    <= '0;
            gap_cnt   <= '0;
            have_prev <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            prev_in <= pulse_in;
            ts_cnt  <= ts_clear ? '0 : ts_cnt + 1'b1;
            if (evt) begin
                gap_cnt   <= '0;
                have_prev <= 1'b1;
            end else if (int'(gap_cnt) < MIN_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    evt_sync_fifo #(.W(TS_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk_slow (clk_slow),
        .rst      (rst),
        .push     (evt),
        .pop      (evt_ready),
        .din      (rec_in),
        .dout     (rec_out),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    assign evt_valid   = !empty;
    assign evt_gap_err = rec_out[TS_W];
    assign evt_ts      = rec_out[TS_W-1:0];

endmodule
